// File: rtl/sha256_axi_pkg.sv
// -----------------------------------------------------------------------------
// sha256_axi_pkg
// Shared constants for the sha256 AXI4-Lite register file: register byte
// offsets, CTRL/STATUS bit positions, AXI response codes, word counts, the
// address-region decode and the byte-strobe merge helper.
// -----------------------------------------------------------------------------
package sha256_axi_pkg;

  // Register byte offsets
  localparam logic [7:0] MSG_BASE    = 8'h00;
  localparam logic [7:0] CTRL_ADDR   = 8'h40;
  localparam logic [7:0] STATUS_ADDR = 8'h44;
  localparam logic [7:0] DIGEST_BASE = 8'h60;

  // CTRL bit positions
  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int CTRL_CLR_ERR_BIT = 7;

  // STATUS bit positions
  localparam int STATUS_READY_BIT   = 0;
  localparam int STATUS_DVALID_BIT  = 1;
  localparam int STATUS_CMD_ERR_BIT = 2;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_MSG_WORDS    = 16;
  localparam int NUM_DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    SEL_MSG    = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_DIGEST = 3'd3,
    SEL_NONE   = 3'd4
  } reg_sel_e;

  // Classify a word address (byte address bits [7:2]) into a register region.
  // Range checks use an unsigned offset so one compare covers both ends.
  function automatic reg_sel_e decode_word(input logic [5:0] word);
    reg_sel_e sel;
    if (6'(word - MSG_BASE[7:2]) < 6'(NUM_MSG_WORDS)) begin
      sel = SEL_MSG;
    end else if (word == CTRL_ADDR[7:2]) begin
      sel = SEL_CTRL;
    end else if (word == STATUS_ADDR[7:2]) begin
      sel = SEL_STATUS;
    end else if (6'(word - DIGEST_BASE[7:2]) < 6'(NUM_DIGEST_WORDS)) begin
      sel = SEL_DIGEST;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  // Merge new write data into an existing word, byte lane by byte lane.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sha256_axi_regs.sv
// -----------------------------------------------------------------------------
// sha256_axi_regs
// AXI4-Lite slave register file in front of the sha256 core.
//   S_AXI_*        : AXI4-Lite slave (single clock, synchronous active-high
//                    reset). One outstanding write and one outstanding read.
//   core_block     : 512-bit message block, MSG0 in bits [511:480].
//   core_init/next : registered one-cycle command pulses to the core.
//   core_ready     : core idle; MSG writes and commands are refused otherwise.
//   core_digest    : 256-bit digest, H0 in bits [255:224], captured into a
//                    shadow whenever core_digest_valid is high.
// -----------------------------------------------------------------------------
module sha256_axi_regs
  import sha256_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [511:0]                    core_block,
  output logic                            core_init,
  output logic                            core_next,
  input  logic                            core_ready,
  input  logic [255:0]                    core_digest,
  input  logic                            core_digest_valid
);

  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [31:0] r_msg    [NUM_MSG_WORDS];
  logic [31:0] r_digest [NUM_DIGEST_WORDS];
  logic        r_cmd_err;
  logic        r_core_init;
  logic        r_core_next;

  logic        w_wr_start;
  logic        w_wr_hs;
  logic        w_rd_start;
  logic        w_rd_hs;
  reg_sel_e    w_wr_sel;
  reg_sel_e    w_rd_sel;
  logic [3:0]  w_wr_msg_idx;
  logic [3:0]  w_rd_msg_idx;
  logic [2:0]  w_rd_dig_idx;
  logic        w_ctrl_wr;
  logic        w_cmd_init;
  logic        w_cmd_next;
  logic        w_cmd_clr;
  logic        w_cmd_err_set;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic        w_unused;

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Handshake qualification and address decode for both channels
  always_comb begin
    w_wr_start   = S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !(r_awready || r_wready);
    w_wr_hs      = r_awready && r_wready && S_AXI_AWVALID && S_AXI_WVALID;
    w_rd_start   = S_AXI_ARVALID && !r_rvalid && !r_arready;
    w_rd_hs      = r_arready && S_AXI_ARVALID;
    w_wr_sel     = decode_word(S_AXI_AWADDR[7:2]);
    w_rd_sel     = decode_word(S_AXI_ARADDR[7:2]);
    w_wr_msg_idx = 4'(S_AXI_AWADDR[7:2] - MSG_BASE[7:2]);
    w_rd_msg_idx = 4'(S_AXI_ARADDR[7:2] - MSG_BASE[7:2]);
    w_rd_dig_idx = 3'(S_AXI_ARADDR[7:2] - DIGEST_BASE[7:2]);
  end

  // CTRL decode: INIT has priority over NEXT; an error set outranks CLR_ERR
  always_comb begin
    w_ctrl_wr     = w_wr_hs && (w_wr_sel == SEL_CTRL) && S_AXI_WSTRB[0];
    w_cmd_init    = w_ctrl_wr && S_AXI_WDATA[CTRL_INIT_BIT];
    w_cmd_next    = w_ctrl_wr && S_AXI_WDATA[CTRL_NEXT_BIT] && !S_AXI_WDATA[CTRL_INIT_BIT];
    w_cmd_clr     = w_ctrl_wr && S_AXI_WDATA[CTRL_CLR_ERR_BIT];
    w_cmd_err_set = (w_cmd_init || w_cmd_next) && !core_ready;
  end

  // Write acceptance, MSG updates and write response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_MSG_WORDS; i++) begin
        r_msg[i] <= 32'h0000_0000;
      end
    end else begin
      r_awready <= w_wr_start;
      r_wready  <= w_wr_start;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        case (w_wr_sel)
          SEL_MSG: begin
            // The block must not move under the core while it is hashing.
            if (core_ready) begin
              r_msg[w_wr_msg_idx] <= apply_wstrb(r_msg[w_wr_msg_idx], S_AXI_WDATA, S_AXI_WSTRB);
              r_bresp             <= RESP_OKAY;
            end else begin
              r_bresp <= RESP_SLVERR;
            end
          end
          SEL_CTRL: r_bresp <= RESP_OKAY;
          default:  r_bresp <= RESP_SLVERR;
        endcase
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end else begin
        r_bvalid <= r_bvalid;
      end
    end
  end

  // Command pulses and sticky command-error flag
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_core_init <= 1'b0;
      r_core_next <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_core_init <= w_cmd_init && core_ready;
      r_core_next <= w_cmd_next && core_ready;
      r_cmd_err   <= w_cmd_err_set || (r_cmd_err && !w_cmd_clr);
    end
  end

  // Digest shadow follows the core while its digest is valid
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_DIGEST_WORDS; i++) begin
        r_digest[i] <= 32'h0000_0000;
      end
    end else if (core_digest_valid) begin
      for (int i = 0; i < NUM_DIGEST_WORDS; i++) begin
        r_digest[i] <= core_digest[255-32*i -: 32];
      end
    end else begin
      for (int i = 0; i < NUM_DIGEST_WORDS; i++) begin
        r_digest[i] <= r_digest[i];
      end
    end
  end

  // Read data/response selection from the decoded read address
  always_comb begin
    w_status                     = 32'h0000_0000;
    w_status[STATUS_READY_BIT]   = core_ready;
    w_status[STATUS_DVALID_BIT]  = core_digest_valid;
    w_status[STATUS_CMD_ERR_BIT] = r_cmd_err;
    w_rd_data                    = 32'h0000_0000;
    w_rd_resp                    = RESP_OKAY;
    case (w_rd_sel)
      SEL_MSG:    w_rd_data = r_msg[w_rd_msg_idx];
      SEL_CTRL:   w_rd_data = 32'h0000_0000;
      SEL_STATUS: w_rd_data = w_status;
      SEL_DIGEST: w_rd_data = r_digest[w_rd_dig_idx];
      default: begin
        w_rd_data = 32'h0000_0000;
        w_rd_resp = RESP_SLVERR;
      end
    endcase
  end

  // Read acceptance and registered read response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= w_rd_start;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= r_rvalid;
      end
    end
  end

  // Message block presented to the core, MSG0 in the top word
  always_comb begin
    core_block = 512'd0;
    for (int i = 0; i < NUM_MSG_WORDS; i++) begin
      core_block[511-32*i -: 32] = r_msg[i];
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign core_init     = r_core_init;
  assign core_next     = r_core_next;

endmodule
